// File: rtl/tm_inference_sequencer.sv
// tm_inference_sequencer: steps a shared clause engine over class/clause/literal chunks and keeps saturated class sums.
// Define TM_SEQ_ARGMAX_EN to build the argmax stage (pred_class/pred_valid); otherwise both are tied 0.
module tm_inference_sequencer #(
    parameter int CLASSES       = 10,
    parameter int CLAUSE_CHUNKS = 63,
    parameter int LA_CHUNKS     = 49,
    parameter int INT_SIZE      = 32,
    localparam int CW = (CLASSES > 1) ? $clog2(CLASSES) : 1,
    localparam int KW = (CLAUSE_CHUNKS > 1) ? $clog2(CLAUSE_CHUNKS) : 1,
    localparam int LW = (LA_CHUNKS > 1) ? $clog2(LA_CHUNKS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_flag,
    input  logic                       stop_flag,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       eng_req,
    input  logic                       eng_ack,
    output logic [CW-1:0]              eng_class,
    output logic [KW-1:0]              eng_clause_chunk,
    output logic [LW-1:0]              eng_la_chunk,
    input  logic signed [INT_SIZE-1:0] eng_vote,
    input  logic [CW-1:0]              sum_sel,
    output logic signed [INT_SIZE-1:0] sum_out,
    output logic [CW-1:0]              pred_class,
    output logic                       pred_valid
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ARGMAX, DONE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cls_q, cls_d;
    logic [KW-1:0] cc_q, cc_d;
    logic [LW-1:0] la_q, la_d;
    logic signed [INT_SIZE-1:0] sums_q [CLASSES];
    logic signed [INT_SIZE-1:0] sums_d [CLASSES];
    logic [INT_SIZE:0] acc_ext;
    logic signed [INT_SIZE-1:0] acc_sat;
    logic la_last, cc_last, cls_last, last_step;
`ifdef TM_SEQ_ARGMAX_EN
    logic signed [INT_SIZE-1:0] best_q, best_d;
    logic [CW-1:0] best_idx_q, best_idx_d, pred_class_q, pred_class_d;
    logic pred_valid_q, pred_valid_d;
`endif
    assign la_last   = la_q == LW'(LA_CHUNKS - 1);
    assign cc_last   = cc_q == KW'(CLAUSE_CHUNKS - 1);
    assign cls_last  = cls_q == CW'(CLASSES - 1);
    assign last_step = la_last && cc_last && cls_last;
    // one extra bit catches overflow; clamp to the signed range when the top two bits disagree
    assign acc_ext = {sums_q[cls_q][INT_SIZE-1], sums_q[cls_q]} + {eng_vote[INT_SIZE-1], eng_vote};
    assign acc_sat = (acc_ext[INT_SIZE] != acc_ext[INT_SIZE-1])
                   ? (acc_ext[INT_SIZE] ? {1'b1, {(INT_SIZE-1){1'b0}}} : {1'b0, {(INT_SIZE-1){1'b1}}})
                   : acc_ext[INT_SIZE-1:0];
    assign busy             = state_q == ISSUE || state_q == WAIT || state_q == ARGMAX;
    assign done             = state_q == DONE && !stop_flag;
    assign eng_req          = state_q == ISSUE || state_q == WAIT;
    assign eng_class        = cls_q;
    assign eng_clause_chunk = cc_q;
    assign eng_la_chunk     = la_q;
    assign sum_out          = (int'(sum_sel) < CLASSES) ? sums_q[sum_sel] : '0;
`ifdef TM_SEQ_ARGMAX_EN
    assign pred_class = pred_class_q;
    assign pred_valid = pred_valid_q;
`else
    assign pred_class = '0;
    assign pred_valid = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cc_d    = cc_q;
        la_d    = la_q;
        sums_d  = sums_q;
`ifdef TM_SEQ_ARGMAX_EN
        best_d       = best_q;
        best_idx_d   = best_idx_q;
        pred_class_d = pred_class_q;
        pred_valid_d = pred_valid_q;
`endif
        if (stop_flag && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = ISSUE;
                    cls_d   = '0;
                    cc_d    = '0;
                    la_d    = '0;
                    for (int c = 0; c < CLASSES; c++) sums_d[c] = '0;
`ifdef TM_SEQ_ARGMAX_EN
                    pred_valid_d = 1'b0;
`endif
                end
                ISSUE: state_d = WAIT;
                WAIT: if (eng_ack) begin
                    if (la_last) sums_d[cls_q] = acc_sat;
                    la_d  = la_last ? '0 : la_q + 1'b1;
                    cc_d  = !la_last ? cc_q : cc_last ? '0 : cc_q + 1'b1;
                    cls_d = !(la_last && cc_last) ? cls_q : cls_last ? '0 : cls_q + 1'b1;
`ifdef TM_SEQ_ARGMAX_EN
                    state_d = last_step ? ARGMAX : ISSUE;
`else
                    state_d = last_step ? DONE : ISSUE;
`endif
                end
`ifdef TM_SEQ_ARGMAX_EN
                ARGMAX: begin
                    // class index doubles as the scan pointer; strict > keeps the lowest index on ties
                    if (cls_q == '0 || sums_q[cls_q] > best_q) begin
                        best_d     = sums_q[cls_q];
                        best_idx_d = cls_q;
                    end
                    cls_d   = cls_last ? '0 : cls_q + 1'b1;
                    state_d = cls_last ? DONE : ARGMAX;
                end
`endif
                DONE: begin
                    state_d = IDLE;
`ifdef TM_SEQ_ARGMAX_EN
                    pred_valid_d = 1'b1;
                    pred_class_d = best_idx_q;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst_flag) begin
        if (rst_flag) begin
            state_q <= IDLE;
            cls_q   <= '0;
            cc_q    <= '0;
            la_q    <= '0;
            for (int c = 0; c < CLASSES; c++) sums_q[c] <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cc_q    <= cc_d;
            la_q    <= la_d;
            sums_q  <= sums_d;
        end
    end
`ifdef TM_SEQ_ARGMAX_EN
    always_ff @(posedge clk or posedge rst_flag) begin
        if (rst_flag) begin
            best_q       <= '0;
            best_idx_q   <= '0;
            pred_class_q <= '0;
            pred_valid_q <= 1'b0;
        end else begin
            best_q       <= best_d;
            best_idx_q   <= best_idx_d;
            pred_class_q <= pred_class_d;
            pred_valid_q <= pred_valid_d;
        end
    end
`endif
endmodule

// File: tb/tb_tm_inference_sequencer.sv
// tb_tm_inference_sequencer: random and directed inference runs against a queue scoreboard.
// Expected sums/argmax come from a plain-arithmetic model; TM_SEQ_ARGMAX_EN selects the expected latency and pred outputs.
module tb_tm_inference_sequencer;
    localparam int NC = 3, CC = 2, LA = 2, IW = 8, NSTEP = NC * CC * LA;
`ifdef TM_SEQ_ARGMAX_EN
    localparam int ARG_CYC = NC;
    localparam int EXP_PV  = 1;
`else
    localparam int ARG_CYC = 0;
    localparam int EXP_PV  = 0;
`endif
    logic clk = 0, rst_flag = 1, stop_flag = 0, start = 0, eng_ack = 0, idle_chk = 0;
    logic busy, done, eng_req, pred_valid;
    logic [1:0] eng_class, pred_class;
    logic [1:0] sum_sel = 0;
    logic [0:0] eng_clause_chunk, eng_la_chunk;
    logic [IW-1:0] eng_vote = 0, sum_out;
    int checks = 0, errors = 0, cyc = 0, consumed = 0, eng_step = 0, stop_step = 0;
    int vote_tbl [NC][CC];
    int dly [NSTEP];
    int step_q [$];
    int res_q [$];

    tm_inference_sequencer #(.CLASSES(NC), .CLAUSE_CHUNKS(CC), .LA_CHUNKS(LA), .INT_SIZE(IW)) dut (
        .clk(clk), .rst_flag(rst_flag), .stop_flag(stop_flag), .start(start), .busy(busy), .done(done),
        .eng_req(eng_req), .eng_ack(eng_ack), .eng_class(eng_class), .eng_clause_chunk(eng_clause_chunk),
        .eng_la_chunk(eng_la_chunk), .eng_vote(eng_vote), .sum_sel(sum_sel), .sum_out(sum_out),
        .pred_class(pred_class), .pred_valid(pred_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return v > 127 ? 127 : (v < -128 ? -128 : v);
    endfunction

    // engine: acks each step dly[] cycles into WAIT; the vote only matters on the last literal chunk
    initial begin
        int d;
        forever begin
            @(posedge clk);
            #1;
            eng_ack   = 0;
            stop_flag = 0;
            if (eng_req && !rst_flag) begin
                d = dly[eng_step % NSTEP];
                for (int i = 0; i <= d; i++) begin
                    @(posedge clk);
                    #1;
                end
                eng_ack  = 1;
                eng_vote = (eng_la_chunk == 1'(LA - 1)) ? IW'(vote_tbl[eng_class][eng_clause_chunk]) : IW'($urandom);
                if (stop_step != 0 && eng_step == stop_step - 1) stop_flag = 1;
                eng_step++;
            end
        end
    end

    // monitor: pops expected steps on consumed acks, expected results on done or an idle check request
    initial begin
        int kind, pc_exp, pv_exp, v;
        forever begin
            @(negedge clk);
            if (!rst_flag) begin
                if (eng_req && eng_ack && !stop_flag) begin
                    consumed++;
                    if (step_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL step_extra: step %0d/%0d/%0d with none expected", eng_class, eng_clause_chunk, eng_la_chunk);
                    end else
                        chk("step_index", int'(eng_class) * 100 + int'(eng_clause_chunk) * 10 + int'(eng_la_chunk), step_q.pop_front());
                end
                if (done || idle_chk) begin
                    if (res_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: done=%0d with no result pending", done);
                    end else begin
                        kind = res_q.pop_front();
                        chk("event_kind", done ? 0 : 1, kind);
                        for (int c = 0; c < NC; c++) begin
                            sum_sel = 2'(c);
                            #1;
                            chk("class_sum", int'($signed(sum_out)), res_q.pop_front());
                        end
                        sum_sel = 2'(NC);
                        #1;
                        chk("sum_out_oob", int'($signed(sum_out)), 0);
                        pc_exp = res_q.pop_front();
                        pv_exp = res_q.pop_front();
                        v      = res_q.pop_front();
                        if (kind == 0) begin
                            chk("done_cycle", cyc, v);
                            @(negedge clk);
                            chk("done_single_pulse", int'(done), 0);
                            chk("idle_busy", int'(busy), 0);
                            chk("pred_valid", int'(pred_valid), pv_exp);
                            chk("pred_class", int'(pred_class), pc_exp);
                        end else begin
                            chk("idle_pred_valid", int'(pred_valid), pv_exp);
                            chk("idle_busy", int'(busy), 0);
                            chk("idle_eng_req", int'(eng_req), 0);
                        end
                    end
                end
            end
        end
    end

    task automatic set_votes(input int a0, input int a1, input int b0, input int b1, input int c0, input int c1);
        vote_tbl[0][0] = a0; vote_tbl[0][1] = a1;
        vote_tbl[1][0] = b0; vote_tbl[1][1] = b1;
        vote_tbl[2][0] = c0; vote_tbl[2][1] = c1;
    endtask

    task automatic rand_votes();
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < CC; k++) vote_tbl[c][k] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic push_idle(input int s0, input int s1, input int s2);
        res_q.push_back(1);
        res_q.push_back(s0);
        res_q.push_back(s1);
        res_q.push_back(s2);
        res_q.push_back(0);
        res_q.push_back(0);
        res_q.push_back(0);
    endtask

    task automatic idle_pulse();
        @(posedge clk);
        #1 idle_chk = 1;
        @(posedge clk);
        #1 idle_chk = 0;
    endtask

    task automatic drain(input string name);
        int b;
        for (b = 0; b < 400 && res_q.size() != 0; b++) @(negedge clk);
        if (res_q.size() != 0 || step_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d results and %0d steps still pending", name, res_q.size(), step_q.size());
            res_q.delete();
            step_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // mode 0: full run, 1: stop on the 5th step, 2: async reset mid-WAIT, 3: full run with a start pulse while busy
    task automatic run(input int mode, input bit fast);
        int s [NC];
        int lat, best, sc, nst, b;
        lat = 0;
        for (int i = 0; i < NSTEP; i++) begin
            dly[i] = fast ? 0 : int'($urandom_range(0, 2));
            lat += 2 + dly[i];
        end
        for (int c = 0; c < NC; c++) s[c] = 0;
        nst = (mode == 1) ? 4 : NSTEP;
        for (int i = 0; i < nst; i++) begin
            step_q.push_back((i / (CC * LA)) * 100 + ((i / LA) % CC) * 10 + i % LA);
            if (i % LA == LA - 1) s[i / (CC * LA)] = sat(s[i / (CC * LA)] + vote_tbl[i / (CC * LA)][(i / LA) % CC]);
        end
        best = 0;
        for (int c = 1; c < NC; c++) if (s[c] > s[best]) best = c;
        consumed  = 0;
        eng_step  = 0;
        stop_step = (mode == 1) ? 5 : 0;
        @(negedge clk);
        sc = cyc;
        if (mode == 0 || mode == 3) begin
            res_q.push_back(0);
            for (int c = 0; c < NC; c++) res_q.push_back(s[c]);
            res_q.push_back(EXP_PV != 0 ? best : 0);
            res_q.push_back(EXP_PV);
            res_q.push_back(sc + lat + ARG_CYC + 1);
        end
        start = 1;
        @(negedge clk);
        start = 0;
        chk("busy_after_start", int'(busy), 1);
        if (mode == 3) begin
            repeat (4) @(negedge clk);
            start = 1;
            @(negedge clk);
            start = 0;
        end
        if (mode == 1) begin
            for (b = 0; b < 200 && busy; b++) @(negedge clk);
            chk("stop_returns_idle", int'(busy), 0);
            repeat (3) @(negedge clk);
            push_idle(s[0], s[1], s[2]);
            idle_pulse();
        end
        if (mode == 2) begin
            for (b = 0; b < 200 && !(consumed >= 3 && eng_ack); b++) @(negedge clk);
            #2 rst_flag = 1;
            #1;
            chk("async_rst_eng_req", int'(eng_req), 0);
            chk("async_rst_busy", int'(busy), 0);
            @(negedge clk);
            rst_flag = 0;
            step_q.delete();
            repeat (4) @(negedge clk);
            push_idle(0, 0, 0);
            idle_pulse();
        end
        stop_step = 0;
        drain("run");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_eng_req", int'(eng_req), 0);
        chk("rst_pred_valid", int'(pred_valid), 0);
        chk("rst_pred_class", int'(pred_class), 0);
        chk("rst_indices", int'(eng_class) * 100 + int'(eng_clause_chunk) * 10 + int'(eng_la_chunk), 0);
        rst_flag = 0;
        push_idle(0, 0, 0);
        idle_pulse();
        drain("reset");
        set_votes(5, -3, 2, 2, -1, 0);
        run(0, 1);
        set_votes(3, 4, 3, 4, 3, 4);
        run(0, 0);
        set_votes(100, 100, -100, -100, 50, -20);
        run(0, 0);
        rand_votes();
        run(1, 0);
        for (int i = 0; i < 5; i++) begin
            rand_votes();
            run(i == 1 ? 3 : 0, 0);
        end
        rand_votes();
        run(2, 0);
        set_votes(5, -3, 2, 2, -1, 0);
        run(0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
